n64_controller_emu: RTL and testbench
=====================================

Name: n64_controller_emu

Overview:
- Emulates an N64 controller on the single-wire Joybus line, sampled by a 2 MHz sample clock (0.5 us per sample).
- Decodes console command bytes from data_rx.
- Answers 0x00 (info/status) and 0xFF (reset/info) with the 3-byte identity, and 0x01 (poll) with the button word plus stick bytes.
- Drives data_tx as an open-drain level: 0 = pull line low, 1 = release.
- Sits between the board's Joybus pad/tristate logic and the button-scanning logic.

Parameters:
- SAMPLES_PER_BIT, 8, sample_clk periods per Joybus bit cell (4 us).
- SAMPLE_POINT, 4, samples after a bit's falling edge at which the bit value is read (2 us).
- TURNAROUND, 4, idle-high samples after the console stop bit before the reply starts.
- TIMEOUT, 64, consecutive high samples inside a command that abort reception.

Ports:
- sample_clk  in  1  2 MHz sample/system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- data_rx  in  1  Joybus line as seen by the controller (console to controller).
- button_state  in  16  button bits, MSB first on the wire: A,B,Z,Start,Dup,Ddown,Dleft,Dright,reset,0,L,R,Cup,Cdown,Cleft,Cright.
- data_tx  out  1  open-drain drive request: 0 = pull low, 1 = release.
- cur_operation  out  1  0 = receiving/idle, 1 = transmitting reply.

Behaviour:
- Reset (rst_n=0 at a clock edge), all of the following:
  - data_tx=1, cur_operation=0, state=IDLE
  - counters cleared; shift registers cleared.
- data_rx passes through a 2-flop synchronizer. Falling edge = synced prev 1, cur 0.
- States: IDLE, RX_BIT, RX_STOP, TURN, TX_BIT, TX_STOP.
- IDLE: on falling edge go to RX_BIT with sample counter=1 and bit counter=0.
- RX_BIT:
  - When the counter reaches SAMPLE_POINT, shift the synced line value into the command register, MSB first (low = 0, high = 1).
  - Next falling edge starts the next bit.
  - After 8 bits, go to RX_STOP.
- RX_BIT abort: if the line stays high for TIMEOUT samples, discard the partial byte and return to IDLE.
- RX_STOP:
  - Wait for the console stop-bit falling edge, then for the line to return high.
  - Command 0x00 or 0xFF: go to TURN, reply = 0x05,0x00,0x02 (24 bits; 0x02 = no pak).
  - Command 0x01: go to TURN, reply = button_state[15:0], stick_x[7:0], stick_y[7:0] (32 bits).
  - Any other command: back to IDLE with no reply.
- button_state is latched into the reply shift register on the RX_STOP to TURN transition. Later changes do not affect the reply in progress.
- TURN: hold data_tx=1 for TURNAROUND samples, then go to TX_BIT with cur_operation=1.
- TX_BIT:
  - Each bit is SAMPLES_PER_BIT samples, MSB first.
  - Bit 0: data_tx=0 for 6 samples, then 1 for 2.
  - Bit 1: data_tx=0 for 2 samples, then 1 for 6.
- TX_STOP: data_tx=0 for 4 samples (2 us), then data_tx=1, cur_operation=0, state=IDLE.
- Receiver is ignored while cur_operation=1; our own drive does not cause decode.
- Reset mid-operation: reset wins immediately; the line is released on the same edge.
- A new command is accepted one sample after returning to IDLE.

Optional Feature:
- Macro N64_ANALOG_STICK_EN.
- Defined: adds input ports stick_x[7:0] and stick_y[7:0] (two's complement). They are latched together with button_state and sent as reply bytes 3 and 4.
- Undefined: no stick ports; bytes 3 and 4 are constant 0x00.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks -> data_tx=1, cur_operation=0 throughout. After release, no activity with data_rx=1.
- Command 0x00 plus stop bit:
  - 4 samples after the line returns high, cur_operation=1.
  - data_tx carries 0x05,0x00,0x02 as 24 cells of 8 samples (0 = 6 low/2 high, 1 = 2 low/6 high).
  - Then 4 low samples, then release with cur_operation=0.
- Command 0x01 with button_state=16'h9001 -> 32-bit reply 0x9001_0000 plus stop bit. Changing button_state to 16'hFFFF mid-reply does not alter it.
- Command 0xFF -> same 24-bit reply as 0x00.
- Command 0x41 -> no reply: data_tx stays 1, cur_operation stays 0, state back to IDLE. A following 0x01 is answered normally.
- Abort cases, each leaving the block able to answer a following 0x00:
  - Only 5 command bits, then line high for 64 samples -> return to IDLE without reply.
  - rst_n=0 asserted mid-reply -> data_tx=1 on the next edge.

Source files
------------

// File: rtl/n64_controller_emu.sv
// N64 controller emulation on the single-wire Joybus line, one sample per sample_clk.
// Optional feature: define N64_ANALOG_STICK_EN to add stick_x/stick_y as reply bytes 3 and 4.
module n64_controller_emu #(
  parameter int SAMPLES_PER_BIT = 8,
  parameter int SAMPLE_POINT    = 4,
  parameter int TURNAROUND      = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic        sample_clk,
  input  logic        rst_n,
  input  logic        data_rx,
  input  logic [15:0] button_state,
`ifdef N64_ANALOG_STICK_EN
  input  logic [7:0]  stick_x,
  input  logic [7:0]  stick_y,
`endif
  output logic        data_tx,
  output logic        cur_operation
);

  localparam logic [7:0] SPB_C      = 8'(SAMPLES_PER_BIT);
  localparam logic [7:0] SP_C       = 8'(SAMPLE_POINT);
  localparam logic [7:0] TA_C       = 8'(TURNAROUND);
  localparam logic [7:0] TO_C       = 8'(TIMEOUT);
  localparam logic [7:0] STOP_C     = 8'(SAMPLES_PER_BIT / 2);
  localparam logic [7:0] ONE_LOW_C  = 8'(SAMPLES_PER_BIT / 4);
  localparam logic [7:0] ZERO_LOW_C = 8'((SAMPLES_PER_BIT * 3) / 4);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_BIT  = 3'd1,
    RX_STOP = 3'd2,
    TURN    = 3'd3,
    TX_BIT  = 3'd4,
    TX_STOP = 3'd5
  } state_t;

  state_t      state_r;
  logic        sync1_r;
  logic        sync2_r;
  logic        prev_r;
  logic [7:0]  samp_cnt_r;
  logic [5:0]  bit_cnt_r;
  logic [7:0]  hi_cnt_r;
  logic [7:0]  cmd_r;
  logic [31:0] tx_shift_r;
  logic        stop_seen_r;
  logic        fall_s;
  logic        rx_timeout_s;
  logic [15:0] stick_s;

`ifdef N64_ANALOG_STICK_EN
  assign stick_s = {stick_x, stick_y};
`else
  assign stick_s = 16'h0000;
`endif

  function automatic logic [7:0] low_len(input logic b);
    return b ? ONE_LOW_C : ZERO_LOW_C;
  endfunction

  assign fall_s       = prev_r & ~sync2_r;
  assign rx_timeout_s = sync2_r & (hi_cnt_r == (TO_C - 8'd1));

  // Two-flop synchronizer on the line, plus a history flop for falling-edge detection
  always_ff @(posedge sample_clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= data_rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Joybus protocol engine: command receive, turnaround and reply transmit
  always_ff @(posedge sample_clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      data_tx       <= 1'b1;
      cur_operation <= 1'b0;
      samp_cnt_r    <= 8'd0;
      bit_cnt_r     <= 6'd0;
      hi_cnt_r      <= 8'd0;
      cmd_r         <= 8'h00;
      tx_shift_r    <= 32'h0000_0000;
      stop_seen_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          data_tx       <= 1'b1;
          cur_operation <= 1'b0;
          if (fall_s) begin
            state_r    <= RX_BIT;
            samp_cnt_r <= 8'd1;
            bit_cnt_r  <= 6'd0;
            hi_cnt_r   <= 8'd0;
            cmd_r      <= 8'h00;
          end
        end
        RX_BIT: begin
          hi_cnt_r <= sync2_r ? (hi_cnt_r + 8'd1) : 8'd0;
          if (rx_timeout_s) begin
            state_r <= IDLE;
            cmd_r   <= 8'h00;
          end else if (samp_cnt_r == SP_C) begin
            cmd_r      <= {cmd_r[6:0], sync2_r};
            samp_cnt_r <= samp_cnt_r + 8'd1;
            if (bit_cnt_r == 6'd7) begin
              state_r     <= RX_STOP;
              stop_seen_r <= 1'b0;
            end else begin
              bit_cnt_r <= bit_cnt_r + 6'd1;
            end
          end else if (fall_s) begin
            samp_cnt_r <= 8'd1;
          end else if (samp_cnt_r != 8'hFF) begin
            // saturate so a stuck-low line can never re-reach the sample point
            samp_cnt_r <= samp_cnt_r + 8'd1;
          end
        end
        RX_STOP: begin
          hi_cnt_r <= sync2_r ? (hi_cnt_r + 8'd1) : 8'd0;
          if (!stop_seen_r) begin
            if (fall_s) begin
              stop_seen_r <= 1'b1;
            end else if (rx_timeout_s) begin
              state_r <= IDLE;
            end
          end else if (sync2_r) begin
            samp_cnt_r <= 8'd0;
            case (cmd_r)
              8'h00, 8'hFF: begin
                state_r    <= TURN;
                tx_shift_r <= {8'h05, 8'h00, 8'h02, 8'h00};
                bit_cnt_r  <= 6'd24;
              end
              8'h01: begin
                state_r    <= TURN;
                tx_shift_r <= {button_state, stick_s};
                bit_cnt_r  <= 6'd32;
              end
              default: begin
                state_r <= IDLE;
              end
            endcase
          end
        end
        TURN: begin
          data_tx <= 1'b1;
          if (samp_cnt_r == (TA_C - 8'd1)) begin
            state_r       <= TX_BIT;
            cur_operation <= 1'b1;
            data_tx       <= 1'b0;
            samp_cnt_r    <= 8'd0;
          end else begin
            samp_cnt_r <= samp_cnt_r + 8'd1;
          end
        end
        TX_BIT: begin
          // data_tx is registered, so it is set for the sample the counter moves to
          if (samp_cnt_r == (SPB_C - 8'd1)) begin
            samp_cnt_r <= 8'd0;
            data_tx    <= 1'b0;
            if (bit_cnt_r == 6'd1) begin
              state_r <= TX_STOP;
            end else begin
              bit_cnt_r  <= bit_cnt_r - 6'd1;
              tx_shift_r <= {tx_shift_r[30:0], 1'b0};
            end
          end else begin
            samp_cnt_r <= samp_cnt_r + 8'd1;
            data_tx    <= ((samp_cnt_r + 8'd1) >= low_len(tx_shift_r[31]));
          end
        end
        TX_STOP: begin
          if (samp_cnt_r == (STOP_C - 8'd1)) begin
            state_r       <= IDLE;
            data_tx       <= 1'b1;
            cur_operation <= 1'b0;
            samp_cnt_r    <= 8'd0;
            bit_cnt_r     <= 6'd0;
            tx_shift_r    <= 32'h0000_0000;
          end else begin
            samp_cnt_r <= samp_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r       <= IDLE;
          data_tx       <= 1'b1;
          cur_operation <= 1'b0;
          samp_cnt_r    <= 8'd0;
          bit_cnt_r     <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n64_controller_emu.sv
// Bench for n64_controller_emu: console commands driven onto a wired-AND line,
// replies decoded from data_tx by a monitor and scored against a reference reply model.
module tb_n64_controller_emu;

  localparam int SPB = 8;
  localparam int TA  = 4;
  localparam int TO  = 64;

  typedef struct {
    int          nbits;
    logic [31:0] data;
    int          rel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        console_drv = 1'b1;
  logic [15:0] buttons = 16'h0000;
  logic        data_tx;
  logic        cur_operation;
  wire         data_rx = console_drv & data_tx;
`ifdef N64_ANALOG_STICK_EN
  logic [7:0]  sx = 8'h00;
  logic [7:0]  sy = 8'h00;
`endif

  exp_t exp_q[$];
  exp_t cur;
  logic cap[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   collecting = 1'b0;
  bit   have_exp = 1'b0;
  bit   rst_prev = 1'b0;
  bit   done = 1'b0;

  n64_controller_emu dut (
    .sample_clk    (clk),
    .rst_n         (rst_n),
    .data_rx       (data_rx),
    .button_state  (buttons),
`ifdef N64_ANALOG_STICK_EN
    .stick_x       (sx),
    .stick_y       (sy),
`endif
    .data_tx       (data_tx),
    .cur_operation (cur_operation)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] stick_val();
`ifdef N64_ANALOG_STICK_EN
    return {sx, sy};
`else
    return 16'h0000;
`endif
  endfunction

  // Reference: which commands are answered and with which bits
  function automatic bit model(input logic [7:0] cmd, input logic [15:0] btn,
                               input logic [15:0] stick, output int nbits,
                               output logic [31:0] data);
    case (cmd)
      8'h00, 8'hFF: begin nbits = 24; data = 32'h0500_0200; return 1'b1; end
      8'h01:        begin nbits = 32; data = {btn, stick};   return 1'b1; end
      default:      begin nbits = 0;  data = 32'h0;          return 1'b0; end
    endcase
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic line(input logic lv, input int n);
    console_drv = lv;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      line(1'b0, b[i] ? 2 : 6);
      line(1'b1, b[i] ? 6 : 2);
    end
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input bit change_mid, input int rst_after);
    exp_t e;
    bit   has;
    int   n;
    send_bits(cmd, 8);
    line(1'b0, 2);
    has   = model(cmd, buttons, stick_val(), e.nbits, e.data);
    e.rel = cyc;
    console_drv = 1'b1;
    if (has) exp_q.push_back(e);
    n = 0;
    while (has && !cur_operation && n < 40) begin @(posedge clk); #1; n++; end
    if (has && change_mid) begin
      buttons = 16'hFFFF;
`ifdef N64_ANALOG_STICK_EN
      sx = 8'h7F;
      sy = 8'h80;
`endif
    end
    if (has && rst_after > 0) begin
      line(1'b1, rst_after);
      rst_n = 1'b0;
      line(1'b1, 2);
      rst_n = 1'b1;
    end
    n = 0;
    while (cur_operation && n < 400) begin @(posedge clk); #1; n++; end
    line(1'b1, has ? 3 : 40);
  endtask

  task automatic compare_reply();
    logic        exp_w[$];
    logic [31:0] dec;
    int          first_bad;
    int          low;
    for (int i = 0; i < cur.nbits; i++) begin
      for (int s = 0; s < SPB; s++)
        exp_w.push_back(s >= (cur.data[31 - i] ? SPB / 4 : (SPB * 3) / 4));
    end
    for (int s = 0; s < SPB / 2; s++) exp_w.push_back(1'b0);
    check(cap.size() == exp_w.size(), "reply_length", 32'(cap.size()), 32'(exp_w.size()));
    first_bad = -1;
    for (int i = 0; i < exp_w.size(); i++)
      if (first_bad < 0 && (i >= cap.size() || cap[i] !== exp_w[i])) first_bad = i;
    check(first_bad < 0, "reply_waveform_first_bad_sample", 32'(first_bad), 32'hFFFF_FFFF);
    dec = 32'h0;
    for (int i = 0; i < cur.nbits; i++) begin
      low = 0;
      for (int s = 0; s < SPB; s++)
        if (i * SPB + s < cap.size() && cap[i * SPB + s] == 1'b0) low++;
      dec[31 - i] = (low <= SPB / 2);
    end
    check(dec == cur.data, "reply_data", dec, cur.data);
  endtask

  // Monitor: samples on the falling clock edge and scores every reply
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done) begin
      check(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end else if (!rst_n) begin
      if (!rst_prev)
        check(data_tx === 1'b1 && cur_operation === 1'b0, "reset_outputs",
              32'({data_tx, cur_operation}), 32'h2);
      collecting = 1'b0;
      cap.delete();
    end else if (collecting) begin
      if (cur_operation) begin
        cap.push_back(data_tx);
        if (cap.size() > 33 * SPB) begin
          check(cap.size() <= 33 * SPB, "reply_length_bound", 32'(cap.size()), 32'(33 * SPB));
          collecting = 1'b0;
        end
      end else begin
        collecting = 1'b0;
        check(data_tx === 1'b1, "release_after_stop", 32'(data_tx), 32'd1);
        if (have_exp) compare_reply();
      end
    end else if (cur_operation) begin
      collecting = 1'b1;
      cap.delete();
      cap.push_back(data_tx);
      check(exp_q.size() > 0, "reply_expected", 32'(exp_q.size()), 32'd1);
      have_exp = (exp_q.size() > 0);
      if (have_exp) begin
        cur = exp_q.pop_front();
        check((cyc - cur.rel) >= TA + 2 && (cyc - cur.rel) <= TA + 5, "turnaround",
              32'(cyc - cur.rel), 32'(TA + 4));
      end
    end else begin
      check(data_tx === 1'b1, "idle_release", 32'(data_tx), 32'd1);
      if (exp_q.size() > 0 && (cyc - exp_q[0].rel) > TA + 20) begin
        check((cyc - exp_q[0].rel) <= TA + 20, "reply_start", 32'(cyc - exp_q[0].rel),
              32'(TA + 4));
        cur = exp_q.pop_front();
      end
    end
    rst_prev = rst_n;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] c;
    rst_n = 1'b0;
    console_drv = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    line(1'b1, 20);
    send_cmd(8'h00, 1'b0, 0);
    buttons = 16'h9001;
    send_cmd(8'h01, 1'b1, 0);
    send_cmd(8'hFF, 1'b0, 0);
    send_cmd(8'h41, 1'b0, 0);
    buttons = 16'h9001;
    send_cmd(8'h01, 1'b0, 0);
    // five-bit fragment, then a long high line must abort reception
    send_bits(8'($urandom), 5);
    line(1'b1, TO + 6);
    send_cmd(8'h00, 1'b0, 0);
    send_cmd(8'h00, 1'b0, 30);
    send_cmd(8'h00, 1'b0, 0);
    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 4))
        0:       c = 8'h00;
        1:       c = 8'hFF;
        2, 3:    c = 8'h01;
        default: c = 8'($urandom);
      endcase
      buttons = 16'($urandom);
`ifdef N64_ANALOG_STICK_EN
      sx = 8'($urandom);
      sy = 8'($urandom);
`endif
      send_cmd(c, 1'($urandom), 0);
    end
    line(1'b1, 10);
    done = 1'b1;
  end

endmodule
